rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter for a shared single-owner resource whose select lines are one-hot. It picks one requester at a time and holds the grant until that requester releases it or a hold timeout expires. It drives a registered one-hot grant plus the matching 2-bit index, so the grant can feed a 2-to-4 select path directly. It sits between four client blocks and the shared resource.

---
 rtl/rr_arbiter4.sv | 124 ++++++++++++
 tb/tb_rr_arbiter4.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered one-hot grant,
// a matching binary index and a per-owner hold timeout.
module rr_arbiter4 #(
    parameter int HOLD_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [3:0]        req,
    output logic [3:0]        gnt,
    output logic [1:0]        gnt_idx,
    output logic              gnt_valid,
    output logic [HOLD_W-1:0] hold_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

    logic [0:0]        state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        own_q, own_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    // Returns {found, index}: first set bit of mask in the order start, start+1, ... mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Walk from the farthest offset down so the nearest requester is written last.
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (mask[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic [2:0] pick_all;
    logic [2:0] pick_oth;
    logic       expire;
    logic       take;
    logic [1:0] take_idx;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d  = state_q;
        ptr_d    = ptr_q;
        own_d    = own_q;
        gnt_d    = gnt_q;
        hold_d   = hold_q;
        take     = 1'b0;
        take_idx = 2'b00;

        pick_all = rr_pick(req, ptr_q);
        pick_oth = rr_pick(req & ~(4'b0001 << own_q), ptr_q);
        expire   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

        case (state_q)
            ST_IDLE: begin
                if (en && pick_all[2]) begin
                    take     = 1'b1;
                    take_idx = pick_all[1:0];
                end
            end
            default: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    gnt_d   = 4'b0000;
                    hold_d  = '0;
                end else if (!req[own_q] || expire) begin
                    if (pick_oth[2]) begin
                        take     = 1'b1;
                        take_idx = pick_oth[1:0];
                    end else if (!req[own_q]) begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                        hold_d  = '0;
                    end else begin
                        // Lone owner at expiry keeps the grant and starts a fresh hold window.
                        hold_d = '0;
                        ptr_d  = own_q + 2'd1;
                    end
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
        endcase

        if (take) begin
            state_d = ST_BUSY;
            own_d   = take_idx;
            gnt_d   = 4'b0001 << take_idx;
            ptr_d   = take_idx + 2'd1;
            hold_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'b00;
            own_q   <= 2'b00;
            gnt_q   <= 4'b0000;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = own_q;
    assign gnt_valid = |gnt_q;
    assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: three instances (timeout 4, timeout 3,
// timeout disabled) sharing clock, reset and enable.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req_a, req_b, req_c;

    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic [1:0] idx_a, idx_b, idx_c;
    logic       val_a, val_b, val_c;
    logic [7:0] hold_a, hold_b, hold_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter4 #(.HOLD_W(8), .MAX_HOLD(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req_a),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a), .hold_cnt(hold_a)
    );

    rr_arbiter4 #(.HOLD_W(8), .MAX_HOLD(3)) u_exp (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req_b),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b), .hold_cnt(hold_b)
    );

    rr_arbiter4 #(.HOLD_W(8), .MAX_HOLD(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req_c),
        .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(val_c), .hold_cnt(hold_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req_a = 4'b0000;
        req_b = 4'b0000;
        req_c = 4'b0000;
        #1;
        check("rst_gnt",   32'(gnt_a),  32'h0);
        check("rst_idx",   32'(idx_a),  32'h0);
        check("rst_valid", 32'(val_a),  32'h0);
        check("rst_hold",  32'(hold_a), 32'h0);

        // Single request
        tick();
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        req_a = 4'b0100;
        tick();
        check("single_gnt",   32'(gnt_a),  32'h4);
        check("single_idx",   32'(idx_a),  32'h2);
        check("single_valid", 32'(val_a),  32'h1);
        check("single_hold0", 32'(hold_a), 32'h0);
        tick();
        check("single_hold1", 32'(hold_a), 32'h1);
        tick();
        check("single_hold2", 32'(hold_a), 32'h2);
        req_a = 4'b0000;
        tick();
        check("drop_gnt",   32'(gnt_a), 32'h0);
        check("drop_valid", 32'(val_a), 32'h0);
        check("drop_idx",   32'(idx_a), 32'h2);

        // Round robin with MAX_HOLD=4
        do_reset();
        req_a = 4'b1111;
        tick();
        for (int k = 0; k < 20; k++) begin
            check($sformatf("rr_idx_%0d", k),  32'(idx_a),  32'((k / 4) % 4));
            check($sformatf("rr_gnt_%0d", k),  32'(gnt_a),  32'(1 << ((k / 4) % 4)));
            check($sformatf("rr_hold_%0d", k), 32'(hold_a), 32'(k % 4));
            tick();
        end
        check("rr_wrap_idx", 32'(idx_a), 32'h1);

        // Release handover from owner 1 to owner 3
        req_a = 4'b1010;
        tick();
        check("pre_release_gnt",  32'(gnt_a),  32'h2);
        check("pre_release_hold", 32'(hold_a), 32'h1);
        req_a = 4'b1000;
        tick();
        check("handover_gnt",   32'(gnt_a),  32'h8);
        check("handover_valid", 32'(val_a),  32'h1);
        check("handover_hold",  32'(hold_a), 32'h0);

        // Enable/disable: owner 2, drop en, pointer stays at 3
        req_a = 4'b0100;
        tick();
        check("own2_gnt", 32'(gnt_a), 32'h4);
        en = 1'b0;
        tick();
        check("dis_gnt",   32'(gnt_a), 32'h0);
        check("dis_valid", 32'(val_a), 32'h0);
        en    = 1'b1;
        req_a = 4'b1101;
        tick();
        check("reen_gnt", 32'(gnt_a), 32'h8);
        check("reen_idx", 32'(idx_a), 32'h3);
        req_a = 4'b0000;

        // Lone owner expiry with MAX_HOLD=3
        do_reset();
        req_b = 4'b0001;
        tick();
        for (int k = 0; k < 7; k++) begin
            check($sformatf("lone_gnt_%0d", k),  32'(gnt_b),  32'h1);
            check($sformatf("lone_idx_%0d", k),  32'(idx_b),  32'h0);
            check($sformatf("lone_hold_%0d", k), 32'(hold_b), 32'(k % 3));
            tick();
        end
        req_b = 4'b0000;

        // Reset mid-grant on the untimed instance
        do_reset();
        req_c = 4'b1000;
        tick();
        check("mid_own3", 32'(gnt_c), 32'h8);
        repeat (5) tick();
        check("mid_hold5", 32'(hold_c), 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt",   32'(gnt_c),  32'h0);
        check("async_idx",   32'(idx_c),  32'h0);
        check("async_hold",  32'(hold_c), 32'h0);
        check("async_valid", 32'(val_c),  32'h0);
        tick();
        rst_n = 1'b1;
        req_c = 4'b1111;
        tick();
        check("post_rst_gnt", 32'(gnt_c), 32'h1);
        check("post_rst_idx", 32'(idx_c), 32'h0);

        // hold_cnt saturates with the timeout disabled
        repeat (254) tick();
        check("sat_254", 32'(hold_c), 32'd254);
        tick();
        check("sat_255", 32'(hold_c), 32'd255);
        repeat (10) tick();
        check("sat_hold", 32'(hold_c), 32'd255);
        check("sat_gnt",  32'(gnt_c),  32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
